me_sched: RTL

Motion-estimation scheduler between the block extractor and a single shared SAD engine. Each `blk_rdy` pulse means a 4x4 reference block and its 7-position search window are available. The block queues that event with its block coordinates and drives the engine through one LOAD plus NCAND compare commands per block. It tracks the minimum SAD and emits one motion result per block, and it aborts and re-aligns at every frame start (`vsync_start`).

---
 rtl/me_sched_pkg.sv | 21 ++
 rtl/me_sched_fifo.sv | 49 ++++
 rtl/me_sched.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/me_sched_pkg.sv
// Shared definitions for the motion-estimation scheduler: engine opcodes,
// FSM state encoding and default geometry.
package me_sched_pkg;

  localparam int ME_NCAND    = 7;
  localparam int ME_BLK_COLS = 480;
  localparam int ME_BLK_ROWS = 270;
  localparam int ME_SAD_W    = 12;

  localparam logic [1:0] ME_OP_LOAD = 2'd0;
  localparam logic [1:0] ME_OP_CMP  = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CMP_ISSUE,
    ST_CMP_WAIT,
    ST_REPORT
  } me_state_e;

endpackage

// File: rtl/me_sched_fifo.sv
// Pending-block queue: first-word-fall-through FIFO of {bx, by} with a flush
// that may load a single entry in the same cycle.
module me_sched_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [W-1:0]           push_data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[flush_i ? '0 : wr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= push_i ? AW'(1) : '0;
      cnt_q <= push_i ? (AW+1)'(1) : '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/me_sched.sv
// Motion-estimation scheduler: queues ready blocks and drives one shared SAD
// engine (LOAD + NCAND CMPs per block). Optional statistics: ME_SCHED_STAT_EN.
module me_sched
  import me_sched_pkg::*;
#(
  parameter int NCAND      = ME_NCAND,
  parameter int BLK_COLS   = ME_BLK_COLS,
  parameter int BLK_ROWS   = ME_BLK_ROWS,
  parameter int SAD_W      = ME_SAD_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync_start,
  input  logic             blk_rdy,
  output logic             cmd_vld,
  input  logic             cmd_rdy,
  output logic [1:0]       cmd_op,
  output logic [2:0]       cmd_cand,
  output logic [8:0]       cmd_bx,
  output logic [8:0]       cmd_by,
  input  logic             res_vld,
  input  logic [SAD_W-1:0] res_sad,
  output logic             mv_vld,
  output logic [2:0]       mv_cand,
  output logic [SAD_W-1:0] mv_sad,
  output logic [8:0]       mv_bx,
  output logic [8:0]       mv_by,
  output logic             drop,
  output logic             busy,
  output logic [17:0]      stat_blk_cnt,
  output logic [15:0]      stat_drop_cnt
);
  localparam int         CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0] K_LAST  = 3'(NCAND - 1);
  localparam logic [8:0] BX_LAST = 9'(BLK_COLS - 1);
  localparam logic [8:0] BY_LAST = 9'(BLK_ROWS - 1);

  me_state_e        state_q, state_d;
  logic [2:0]       k_q, k_d;
  logic [8:0]       wbx_q, wbx_d, wby_q, wby_d;
  logic [8:0]       cbx_q, cbx_d, cby_q, cby_d;
  logic [2:0]       best_cand_q, best_cand_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic             cmd_vld_q, mv_vld_q, drop_q, busy_q;
  logic [1:0]       cmd_op_q;
  logic             pop, push_acc, drop_d, busy_d;
  logic             fifo_full, fifo_empty;
  logic [17:0]      fifo_head, push_data;
  logic [CW-1:0]    fifo_cnt, fifo_cnt_next;

  // A frame start re-aligns the queue, so the coincident block always fits.
  assign push_acc      = blk_rdy && (vsync_start || !fifo_full || pop);
  assign drop_d        = blk_rdy && !push_acc;
  assign push_data     = vsync_start ? '0 : {cbx_q, cby_q};
  assign fifo_cnt_next = fifo_cnt + CW'(push_acc) - CW'(pop);
  assign busy_d        = (state_d != ST_IDLE) ||
                         (vsync_start ? push_acc : (fifo_cnt_next != '0));

  me_sched_fifo #(.DEPTH(FIFO_DEPTH), .W(18)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (vsync_start),
    .push_i      (push_acc),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    wbx_d       = wbx_q;
    wby_d       = wby_q;
    best_cand_d = best_cand_q;
    best_sad_d  = best_sad_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          wbx_d   = fifo_head[17:9];
          wby_d   = fifo_head[8:0];
          k_d     = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD:      if (cmd_rdy) state_d = ST_CMP_ISSUE;
      ST_CMP_ISSUE: if (cmd_rdy) state_d = ST_CMP_WAIT;
      ST_CMP_WAIT: begin
        if (res_vld) begin
          // Strict compare: ties keep the lowest candidate index.
          if (k_q == '0 || res_sad < best_sad_q) begin
            best_cand_d = k_q;
            best_sad_d  = res_sad;
          end
          if (k_q == K_LAST) begin
            state_d = ST_REPORT;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = ST_CMP_ISSUE;
          end
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (vsync_start) begin
      state_d = ST_IDLE;
      pop     = 1'b0;
    end
  end

  always_comb begin
    cbx_d = cbx_q;
    cby_d = cby_q;
    if (vsync_start) begin
      cbx_d = blk_rdy ? 9'd1 : 9'd0;
      cby_d = '0;
    end else if (push_acc) begin
      if (cbx_q == BX_LAST) begin
        cbx_d = '0;
        cby_d = (cby_q == BY_LAST) ? 9'd0 : cby_q + 1'b1;
      end else begin
        cbx_d = cbx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      wbx_q       <= '0;
      wby_q       <= '0;
      cbx_q       <= '0;
      cby_q       <= '0;
      best_cand_q <= '0;
      best_sad_q  <= '0;
      cmd_vld_q   <= 1'b0;
      cmd_op_q    <= ME_OP_LOAD;
      mv_vld_q    <= 1'b0;
      drop_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      wbx_q       <= wbx_d;
      wby_q       <= wby_d;
      cbx_q       <= cbx_d;
      cby_q       <= cby_d;
      best_cand_q <= best_cand_d;
      best_sad_q  <= best_sad_d;
      cmd_vld_q   <= (state_d == ST_LOAD) || (state_d == ST_CMP_ISSUE);
      cmd_op_q    <= (state_d == ST_CMP_ISSUE) ? ME_OP_CMP : ME_OP_LOAD;
      mv_vld_q    <= (state_d == ST_REPORT);
      drop_q      <= drop_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_vld  = cmd_vld_q;
  assign cmd_op   = cmd_op_q;
  assign cmd_cand = k_q;
  assign cmd_bx   = wbx_q;
  assign cmd_by   = wby_q;
  assign mv_vld   = mv_vld_q;
  assign mv_cand  = best_cand_q;
  assign mv_sad   = best_sad_q;
  assign mv_bx    = wbx_q;
  assign mv_by    = wby_q;
  assign drop     = drop_q;
  assign busy     = busy_q;

`ifdef ME_SCHED_STAT_EN
  logic [17:0] blk_cnt_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || vsync_start) begin
      blk_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (state_d == ST_REPORT && blk_cnt_q != '1) blk_cnt_q <= blk_cnt_q + 1'b1;
      if (drop_d && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign stat_blk_cnt  = blk_cnt_q;
  assign stat_drop_cnt = drop_cnt_q;
`else
  assign stat_blk_cnt  = '0;
  assign stat_drop_cnt = '0;
`endif

endmodule
